wb_burst_reader: RTL

Single-clock Wishbone B3 burst-read master that fetches a contiguous word range from memory (typically through the SDRAM controller's Wishbone port) and presents it as a ready/valid 32-bit stream, e.g. framebuffer scan-out. A software- or sequencer-issued job (base address, word count) is split into linear incrementing bursts. A burst is started only when the internal FIFO can absorb all of its beats, so the bus is never stalled by the consumer.

---
 rtl/wb_pkg.sv | 19 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/wb_burst_reader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Wishbone B3 registered-feedback cycle type (CTI) and burst type (BTE) encodings
// shared with the SDRAM controller's Wishbone port.
package wb_pkg;

  typedef enum logic [2:0] {
    CLASSIC     = 3'b000,
    CONST_BURST = 3'b001,
    INC_BURST   = 3'b010,
    END_BURST   = 3'b111
  } wb_cti_e;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } wb_bte_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with occupancy and free-slot counts.
// The head word is always visible on rd_data whenever empty is low.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   free
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  push, pop;

  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign full    = (cnt == DEPTH_L);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign free    = DEPTH_L - cnt;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; pointers and count define validity, and a
  // resettable array would cost a reset net per bit for no functional gain.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (ADDR_WIDTH + 1)'(1);
        2'b01:   cnt <= cnt - (ADDR_WIDTH + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Space is reserved upstream before each burst, so a push into a full FIFO is a bug.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) assert (!full) else $error("sync_fifo: push while full");
  end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone B3 burst-read master: splits a (base, length) job into linear incrementing
// bursts and streams the fetched words out through a FWFT FIFO.
module wb_burst_reader
  import wb_pkg::*;
#(
  parameter int BURST_LEN = 8,
  parameter int FIFO_AW   = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        start_i,
  input  logic [31:0] base_adr_i,
  input  logic [23:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [31:0] dat_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, DONE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         adr_q, adr_d;
  logic [23:0]         rem_q, rem_d;
  logic [BEAT_W-1:0]   beats_q, beats_d, burst_beats;
  logic                cyc_q, cyc_d;
  wb_cti_e             cti_q, cti_d;
  logic                err_q, err_d;

  logic                fifo_push, fifo_full, fifo_empty, bus_err, space_ok;
  logic [FIFO_AW:0]    fifo_count, fifo_free;
  logic                unused_ok;

  assign bus_err   = cyc_q & wb_err_i;
  assign fifo_push = cyc_q & wb_ack_i & ~wb_err_i;

  assign burst_beats = (rem_q >= 24'(BURST_LEN)) ? BEAT_W'(BURST_LEN) : rem_q[BEAT_W-1:0];
  assign space_ok    = 32'(fifo_free) >= 32'(burst_beats);

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        adr_d   = {base_adr_i[31:2], 2'b00};
        rem_d   = len_i;
        err_d   = 1'b0;
        state_d = (len_i == '0) ? DONE : WAIT_SPACE;
      end
      WAIT_SPACE: if (space_ok) begin
        beats_d = burst_beats;
        cyc_d   = 1'b1;
        cti_d   = (burst_beats == BEAT_W'(1)) ? CLASSIC : INC_BURST;
        state_d = BURST;
      end
      BURST: begin
        if (bus_err) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          cti_d   = CLASSIC;
          state_d = DONE;
        end else if (fifo_push) begin
          adr_d   = adr_q + 32'd4;
          rem_d   = rem_q - 24'd1;
          beats_d = beats_q - BEAT_W'(1);
          if (beats_q == BEAT_W'(1)) begin
            cyc_d   = 1'b0;
            cti_d   = CLASSIC;
            state_d = (rem_q == 24'd1) ? DONE : WAIT_SPACE;
          end else begin
            // The beat after this ack is the last one when only two remain.
            cti_d = (beats_q == BEAT_W'(2)) ? END_BURST : INC_BURST;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= CLASSIC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      cyc_q   <= cyc_d;
      cti_q   <= cti_d;
      err_q   <= err_d;
    end
  end

  sync_fifo #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(FIFO_AW)
  ) u_fifo (
    .clk    (wb_clk),
    .rst    (wb_rst),
    .wr_en  (fifo_push),
    .wr_data(wb_dat_i),
    .rd_en  (ready_i),
    .rd_data(dat_o),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count),
    .free   (fifo_free)
  );

  assign unused_ok = ^{fifo_count, fifo_full, base_adr_i[1:0]};

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign err_o    = err_q;
  assign wb_adr_o = adr_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;
  assign wb_cti_o = cti_q;
  assign wb_bte_o = LINEAR;
  assign valid_o  = ~fifo_empty;

endmodule
